lsu_ctrl: RTL

- Multi-cycle load/store sequencer between the single-cycle core's decode/ALU stage and a handshaked data memory.
- Takes the decoder's Load/Store strobes, fun3 and the ALU-computed address, then drives a word-aligned request with byte mask.
- Stalls the core until the access completes and returns sign/zero-extended load data for writeback.
- Flags misaligned, illegal-size and timed-out accesses.

---
 rtl/lsu_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: turns decoded load/store strobes into a handshaked,
// word-aligned memory access and stalls the core until it completes.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  fun3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic [2:0]  fun3_q, fun3_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] ldata_q, ldata_d;
  logic        timeout_q, timeout_d;

  logic        fun3_ok_s, misaligned_s, issue_s;
  logic [1:0]  fault_s;
  logic [31:0] wdata_s, ext_s;
  logic [3:0]  wmask_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Request legality: both strobes, then bad size, then alignment.
  always_comb begin
    fun3_ok_s    = 1'b0;
    misaligned_s = 1'b0;
    fault_s      = 2'b00;
    if (load) begin
      case (fun3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: fun3_ok_s = 1'b1;
        default:                                fun3_ok_s = 1'b0;
      endcase
    end else begin
      fun3_ok_s = (fun3 == 3'b000) || (fun3 == 3'b001) || (fun3 == 3'b010);
    end
    case (fun3[1:0])
      2'b01:   misaligned_s = addr[0];
      2'b10:   misaligned_s = (addr[1:0] != 2'b00);
      default: misaligned_s = 1'b0;
    endcase
    if (!(load || store))   fault_s = 2'b00;
    else if (load && store) fault_s = 2'b11;
    else if (!fun3_ok_s)    fault_s = 2'b11;
    else if (misaligned_s)  fault_s = 2'b01;
    else                    fault_s = 2'b00;
    issue_s = (state_q == IDLE) && (load || store) && (fault_s == 2'b00);
  end

  // Store lane placement and load lane extraction.
  always_comb begin
    case (fun3[1:0])
      2'b00: begin
        wdata_s = {4{store_data[7:0]}};
        wmask_s = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        wdata_s = {2{store_data[15:0]}};
        wmask_s = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_s = store_data;
        wmask_s = 4'b1111;
      end
    endcase
    byte_s = mem_rdata[8*lane_q +: 8];
    half_s = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (fun3_q)
      3'b000:  ext_s = {{24{byte_s[7]}}, byte_s};
      3'b100:  ext_s = {24'd0, byte_s};
      3'b001:  ext_s = {{16{half_s[15]}}, half_s};
      3'b101:  ext_s = {16'd0, half_s};
      default: ext_s = mem_rdata;
    endcase
  end

  // Sequencer next-state.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    fun3_d      = fun3_q;
    lane_d      = lane_q;
    cnt_d       = cnt_q;
    ldata_d     = ldata_q;
    timeout_d   = timeout_q;
    case (state_q)
      IDLE: begin
        if (issue_s) begin
          state_d     = BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = store;
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_wdata_d = wdata_s;
          mem_wmask_d = store ? wmask_s : 4'b0000;
          fun3_d      = fun3;
          lane_d      = addr[1:0];
          cnt_d       = 8'd0;
          timeout_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // An ack coinciding with the timeout limit still completes the access.
        if (mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          ldata_d   = ext_s;
        end else if (cnt_q == TO_LAST) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wmask_q <= 4'd0;
      fun3_q      <= 3'd0;
      lane_q      <= 2'd0;
      cnt_q       <= 8'd0;
      ldata_q     <= 32'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      fun3_q      <= fun3_d;
      lane_q      <= lane_d;
      cnt_q       <= cnt_d;
      ldata_q     <= ldata_d;
      timeout_q   <= timeout_d;
    end
  end

  // Core-facing status; error in IDLE is reported in the request cycle.
  always_comb begin
    stall      = issue_s || (state_q == BUSY);
    load_valid = (state_q == DONE) && !timeout_q && !mem_we_q;
    load_data  = load_valid ? ldata_q : 32'd0;
    if ((state_q == IDLE) && (fault_s != 2'b00)) begin
      err      = 1'b1;
      err_code = fault_s;
    end else if ((state_q == DONE) && timeout_q) begin
      err      = 1'b1;
      err_code = 2'b10;
    end else begin
      err      = 1'b0;
      err_code = 2'b00;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;

endmodule
